// File: rtl/fifo_fwft_sync.sv
// ---------------------------------------------------------------------------
// fifo_fwft_sync
// Single-clock first-word-fall-through FIFO. The head word is always presented
// on dout while empty is low, and rden acknowledges (pops) that word.
//
// Storage is a RAM of DEPTH-1 entries plus one output register (dout), so the
// total capacity is DEPTH = 2**DEPTH_WIDTH words. Every accepted write goes
// into the RAM. The output register reloads from the RAM whenever it is empty
// or being popped. A word written into an empty FIFO therefore appears on dout
// one edge after it was written.
//
// Optional build macro:
//   FIFO_FILL_LEVEL_EN - adds the registered output fill_level[DEPTH_WIDTH:0]
//                        holding the total occupancy, output register included.
// ---------------------------------------------------------------------------
module fifo_fwft_sync #(
  parameter int WIDTH       = 8,   // data word width, >= 1
  parameter int DEPTH_WIDTH = 4    // log2 of total capacity, >= 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // write side: plain push interface
  input  logic [WIDTH-1:0]       din,
  input  logic                   wren,
  output logic                   full,
  // read side: FWFT head word plus pop acknowledge
  output logic [WIDTH-1:0]       dout,
  input  logic                   rden,
  output logic                   empty
`ifdef FIFO_FILL_LEVEL_EN
  ,
  output logic [DEPTH_WIDTH:0]   fill_level
`endif
);

  // -------------------------------------------------------------------------
  // Derived sizes
  // -------------------------------------------------------------------------
  localparam int unsigned             DEPTH     = 1 << DEPTH_WIDTH;
  localparam int unsigned             RAM_DEPTH = DEPTH - 1;
  localparam logic [DEPTH_WIDTH-1:0]  PTR_LAST  = DEPTH_WIDTH'(RAM_DEPTH - 1);
  localparam logic [DEPTH_WIDTH-1:0]  PTR_ZERO  = '0;
  localparam logic [DEPTH_WIDTH:0]    CNT_FULL  = (DEPTH_WIDTH + 1)'(DEPTH);
  localparam logic [DEPTH_WIDTH:0]    CNT_ONE   = (DEPTH_WIDTH + 1)'(1);
  localparam logic [DEPTH_WIDTH:0]    CNT_ZERO  = '0;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0]        mem_q [RAM_DEPTH];  // RAM body, excludes dout
  logic [DEPTH_WIDTH-1:0]  wr_ptr_q, wr_ptr_d; // next RAM slot to write
  logic [DEPTH_WIDTH-1:0]  rd_ptr_q, rd_ptr_d; // oldest RAM slot
  logic [DEPTH_WIDTH:0]    count_q,  count_d;  // total occupancy 0..DEPTH
  logic [WIDTH-1:0]        dout_q,   dout_d;   // output register
  logic                    empty_q,  empty_d;  // output register holds no word
  logic                    full_q,   full_d;   // occupancy == DEPTH

  // -------------------------------------------------------------------------
  // Handshake decode
  // -------------------------------------------------------------------------
  logic                    wr_accept;   // word pushed into RAM this edge
  logic                    rd_accept;   // head word popped this edge
  logic [DEPTH_WIDTH:0]    ram_count;   // words held in the RAM alone
  logic                    ram_has_word;
  logic                    load_out;    // move oldest RAM word into dout

  // A push while full is dropped outright, even when a pop happens on the
  // same edge; a pop while empty is ignored.
  assign wr_accept = wren & ~full_q;
  assign rd_accept = rden & ~empty_q;

  // The RAM holds everything except the word sitting in the output register.
  assign ram_count    = count_q - (empty_q ? CNT_ZERO : CNT_ONE);
  assign ram_has_word = (ram_count != CNT_ZERO);

  // The output register refills from the RAM when it is vacant or is being
  // popped. A word written on this very edge is not yet visible in the RAM,
  // which gives the one-cycle fall-through latency.
  assign load_out = ram_has_word & (empty_q | rd_accept);

  // -------------------------------------------------------------------------
  // Pointer wrap helper: pointers wrap modulo DEPTH-1. With DEPTH_WIDTH=1 the
  // RAM has a single slot, so PTR_LAST is zero and the pointer never moves.
  // -------------------------------------------------------------------------
  function automatic logic [DEPTH_WIDTH-1:0] ptr_inc(input logic [DEPTH_WIDTH-1:0] ptr);
    if (ptr == PTR_LAST) begin
      return PTR_ZERO;
    end
    return ptr + 1'b1;
  endfunction

  // Next-state computation for pointers, occupancy, flags and output register.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path can leave one unassigned and infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    empty_d  = empty_q;
    full_d   = full_q;

    if (wr_accept) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end

    if (load_out) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
      dout_d   = mem_q[rd_ptr_q];
    end

    // Total occupancy: a simultaneous push and pop leaves it unchanged.
    unique case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // dout stays valid if it was valid and not popped, or if it is refilled.
    empty_d = ~((~empty_q & ~rd_accept) | load_out);

    // full tracks the next occupancy so it is registered yet exact.
    full_d  = (count_d == CNT_FULL);
  end

  // Control and output register state, cleared by asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      count_q  <= CNT_ZERO;
      dout_q   <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  // RAM write port.
  // NOTE: the storage array has no reset; its contents are never observed
  // before being written because the pointers and count are reset, and a
  // resettable array would prevent mapping onto RAM primitives.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign dout  = dout_q;
  assign empty = empty_q;
  assign full  = full_q;

`ifdef FIFO_FILL_LEVEL_EN
  // Total occupancy, counting the word in flight during fall-through.
  assign fill_level = count_q;
`endif

  // -------------------------------------------------------------------------
  // Structural invariants
  // -------------------------------------------------------------------------
  // Occupancy can never exceed capacity.
  a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= CNT_FULL);

  // A full FIFO always has a word presented on dout.
  a_not_full_and_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(full_q && empty_q));

  // The full flag always agrees with the occupancy counter.
  a_full_matches_count: assert property (@(posedge clk) disable iff (!rst_n)
    full_q == (count_q == CNT_FULL));

  // An empty output register implies at most the single fall-through word.
  a_empty_occupancy: assert property (@(posedge clk) disable iff (!rst_n)
    empty_q |-> (count_q <= CNT_ONE));

endmodule

// File: tb/tb_fifo_fwft_sync.sv
// ---------------------------------------------------------------------------
// tb_fifo_fwft_sync
// Directed bench for fifo_fwft_sync. Two instances share clock and reset:
// u_dut3 (DEPTH_WIDTH=3, capacity 8) and u_dut2 (DEPTH_WIDTH=2, capacity 4).
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// Build with FIFO_FILL_LEVEL_EN defined to also check fill_level.
// ---------------------------------------------------------------------------
module tb_fifo_fwft_sync;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;

  logic [W-1:0] din3  = '0;
  logic         wren3 = 1'b0;
  logic         rden3 = 1'b0;
  logic [W-1:0] dout3;
  logic         full3, empty3;

  logic [W-1:0] din2  = '0;
  logic         wren2 = 1'b0;
  logic         rden2 = 1'b0;
  logic [W-1:0] dout2;
  logic         full2, empty2;

`ifdef FIFO_FILL_LEVEL_EN
  logic [3:0]   fill3;
  logic [2:0]   fill2;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_fwft_sync #(.WIDTH(W), .DEPTH_WIDTH(3)) u_dut3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din3),
    .wren       (wren3),
    .full       (full3),
    .dout       (dout3),
    .rden       (rden3),
    .empty      (empty3)
`ifdef FIFO_FILL_LEVEL_EN
    ,
    .fill_level (fill3)
`endif
  );

  fifo_fwft_sync #(.WIDTH(W), .DEPTH_WIDTH(2)) u_dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din2),
    .wren       (wren2),
    .full       (full2),
    .dout       (dout2),
    .rden       (rden2),
    .empty      (empty2)
`ifdef FIFO_FILL_LEVEL_EN
    ,
    .fill_level (fill2)
`endif
  );

  // Advance to just after the next rising edge.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulsed mid-cycle, then a clean release.
  task automatic test_reset;
    // Put a word on each dout so the reset has something to clear.
    wren3 = 1'b1; din3 = 8'h5A;
    wren2 = 1'b1; din2 = 8'h66;
    step;
    wren3 = 1'b0; wren2 = 1'b0;
    step;
    n_cmp++; if (dout3 !== 8'h5A) begin n_err++; $display("FAIL pre_reset_dout3: got %h want 5a", dout3); end
    // Mid-cycle assertion, checked before any clock edge.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (empty3 !== 1'b1) begin n_err++; $display("FAIL reset_empty3: got %b want 1", empty3); end
    n_cmp++; if (full3  !== 1'b0) begin n_err++; $display("FAIL reset_full3: got %b want 0", full3); end
    n_cmp++; if (dout3  !== 8'h00) begin n_err++; $display("FAIL reset_dout3: got %h want 00", dout3); end
    n_cmp++; if (empty2 !== 1'b1) begin n_err++; $display("FAIL reset_empty2: got %b want 1", empty2); end
    n_cmp++; if (dout2  !== 8'h00) begin n_err++; $display("FAIL reset_dout2: got %h want 00", dout2); end
`ifdef FIFO_FILL_LEVEL_EN
    n_cmp++; if (fill3 !== 4'd0) begin n_err++; $display("FAIL reset_fill3: got %0d want 0", fill3); end
`endif
    step;
    rst_n = 1'b1;
    step;
    n_cmp++; if (empty3 !== 1'b1) begin n_err++; $display("FAIL post_reset_empty3: got %b want 1", empty3); end
    n_cmp++; if (full2  !== 1'b0) begin n_err++; $display("FAIL post_reset_full2: got %b want 0", full2); end
  endtask

  // Single word falls through one edge after it is written, then is popped.
  task automatic test_fall_through;
    wren3 = 1'b1; din3 = 8'hA5;
    step;                                   // edge N
    wren3 = 1'b0;
    n_cmp++; if (empty3 !== 1'b1) begin n_err++; $display("FAIL ft_empty_n: got %b want 1", empty3); end
`ifdef FIFO_FILL_LEVEL_EN
    n_cmp++; if (fill3 !== 4'd1) begin n_err++; $display("FAIL ft_fill_n: got %0d want 1", fill3); end
`endif
    step;                                   // edge N+1
    n_cmp++; if (empty3 !== 1'b0) begin n_err++; $display("FAIL ft_empty_n1: got %b want 0", empty3); end
    n_cmp++; if (dout3 !== 8'hA5) begin n_err++; $display("FAIL ft_dout_n1: got %h want a5", dout3); end
    // Holds while not popped.
    step;
    n_cmp++; if (dout3 !== 8'hA5) begin n_err++; $display("FAIL ft_dout_hold: got %h want a5", dout3); end
    rden3 = 1'b1;
    step;                                   // pop
    rden3 = 1'b0;
    n_cmp++; if (empty3 !== 1'b1) begin n_err++; $display("FAIL ft_empty_pop: got %b want 1", empty3); end
`ifdef FIFO_FILL_LEVEL_EN
    n_cmp++; if (fill3 !== 4'd0) begin n_err++; $display("FAIL ft_fill_pop: got %0d want 0", fill3); end
`endif
  endtask

  // Pops while empty are ignored; a later write still reads back correctly.
  task automatic test_underflow;
    rden3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step;
      n_cmp++; if (empty3 !== 1'b1) begin n_err++; $display("FAIL uf_empty_%0d: got %b want 1", i, empty3); end
    end
    rden3 = 1'b0;
    wren3 = 1'b1; din3 = 8'h3C;
    step;
    wren3 = 1'b0;
    step;
    n_cmp++; if (empty3 !== 1'b0) begin n_err++; $display("FAIL uf_empty_after_wr: got %b want 0", empty3); end
    n_cmp++; if (dout3 !== 8'h3C) begin n_err++; $display("FAIL uf_dout: got %h want 3c", dout3); end
    rden3 = 1'b1;
    step;
    rden3 = 1'b0;
    n_cmp++; if (empty3 !== 1'b1) begin n_err++; $display("FAIL uf_empty_drained: got %b want 1", empty3); end
  endtask

  // Capacity-4 FIFO: fifth write dropped, drain returns the first four.
  task automatic test_fill_overflow;
    for (int i = 1; i <= 5; i++) begin
      wren2 = 1'b1; din2 = 8'(i);
      step;
      n_cmp++;
      if (full2 !== (i >= 4)) begin
        n_err++; $display("FAIL fill_full_after_wr%0d: got %b want %b", i, full2, (i >= 4));
      end
    end
    wren2 = 1'b0;
`ifdef FIFO_FILL_LEVEL_EN
    n_cmp++; if (fill2 !== 3'd4) begin n_err++; $display("FAIL fill_level2: got %0d want 4", fill2); end
`endif
    for (int i = 1; i <= 4; i++) begin
      n_cmp++; if (empty2 !== 1'b0) begin n_err++; $display("FAIL drain_empty_%0d: got %b want 0", i, empty2); end
      n_cmp++; if (dout2 !== 8'(i)) begin n_err++; $display("FAIL drain_dout_%0d: got %h want %h", i, dout2, 8'(i)); end
      rden2 = 1'b1;
      step;
      rden2 = 1'b0;
      if (i == 1) begin
        n_cmp++; if (full2 !== 1'b0) begin n_err++; $display("FAIL drain_full_clear: got %b want 0", full2); end
      end
    end
    n_cmp++; if (empty2 !== 1'b1) begin n_err++; $display("FAIL drain_empty_end: got %b want 1", empty2); end
  endtask

  // Capacity-8 FIFO at full: push+pop on one edge pops 0x10 and drops 0xFF.
  task automatic test_full_simul;
    for (int i = 0; i < 8; i++) begin
      wren3 = 1'b1; din3 = 8'h10 + 8'(i);
      step;
      if (i == 6) begin
        n_cmp++; if (full3 !== 1'b0) begin n_err++; $display("FAIL sim_full_at7: got %b want 0", full3); end
      end
    end
    wren3 = 1'b0;
    n_cmp++; if (full3 !== 1'b1) begin n_err++; $display("FAIL sim_full_at8: got %b want 1", full3); end
    n_cmp++; if (dout3 !== 8'h10) begin n_err++; $display("FAIL sim_head: got %h want 10", dout3); end
    wren3 = 1'b1; din3 = 8'hFF; rden3 = 1'b1;
    step;
    wren3 = 1'b0; rden3 = 1'b0;
    n_cmp++; if (full3 !== 1'b0) begin n_err++; $display("FAIL sim_full_after: got %b want 0", full3); end
`ifdef FIFO_FILL_LEVEL_EN
    n_cmp++; if (fill3 !== 4'd7) begin n_err++; $display("FAIL sim_fill: got %0d want 7", fill3); end
`endif
    for (int i = 1; i < 8; i++) begin
      n_cmp++;
      if (dout3 !== 8'h10 + 8'(i)) begin
        n_err++; $display("FAIL sim_drain_%0d: got %h want %h", i, dout3, 8'h10 + 8'(i));
      end
      rden3 = 1'b1;
      step;
      rden3 = 1'b0;
    end
    n_cmp++; if (empty3 !== 1'b1) begin n_err++; $display("FAIL sim_empty_end: got %b want 1", empty3); end
  endtask

  // 200 incrementing words with random push/pop at ~50% each, across wraps.
  task automatic test_stream;
    int sent = 0;
    int rcvd = 0;
    int cyc  = 0;
    while (rcvd < 200 && cyc < 5000) begin
      wren3 = (sent < 200) && ($urandom_range(0, 1) == 1);
      din3  = 8'(sent);
      rden3 = ($urandom_range(0, 1) == 1);
      if (wren3 && !full3) sent++;
      if (rden3 && !empty3) begin
        n_cmp++;
        if (dout3 !== 8'(rcvd)) begin
          n_err++; $display("FAIL stream_word_%0d: got %h want %h", rcvd, dout3, 8'(rcvd));
        end
        rcvd++;
      end
      step;
      cyc++;
    end
    wren3 = 1'b0; rden3 = 1'b0;
    n_cmp++; if (rcvd != 200) begin n_err++; $display("FAIL stream_count: got %0d want 200 (cycle budget hit)", rcvd); end
    step;
    n_cmp++; if (empty3 !== 1'b1) begin n_err++; $display("FAIL stream_empty_end: got %b want 1", empty3); end
  endtask

  initial begin
    step;
    step;
    rst_n = 1'b1;
    step;
    test_reset;
    test_fall_through;
    test_underflow;
    test_fill_overflow;
    test_full_simul;
    test_stream;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
